byte_serializer: RTL and testbench

- Downstream neighbour of the 32-bit word splitter in the P0 component set.
- Accepts one 32-bit word over a valid/ready handshake and emits its four bytes one per cycle over a second valid/ready handshake.
- Default byte order is MSB first: A[31:24], A[23:16], A[15:8], A[7:0]. This matches the splitter's O1..O4 ordering.
- Consumers are narrow 8-bit paths such as a UART TX or a byte-wide memory port.

---
 rtl/byte_serializer_if.sv | 31 +++
 rtl/byte_serializer.sv | 135 +++++++++++++
 tb/tb_byte_serializer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/byte_serializer_if.sv
// Handshake bundle for byte_serializer: a word-wide valid/ready input
// channel and a byte-wide valid/ready output channel with an end-of-word
// marker. The serializer connects through the slave modport. The
// environment that feeds words and drains bytes uses the master modport.
interface byte_serializer_if #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
);
  // Upstream word channel
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;

  // Downstream byte channel
  logic              out_valid;
  logic [BYTE_W-1:0] out_data;
  logic              out_ready;
  logic              out_last;

  // Environment side: produces words, consumes bytes.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Serializer side: consumes words, produces bytes.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: accepts one NUM_BYTES*BYTE_W-bit word over a valid/ready
// handshake and emits its bytes one per cycle over a second valid/ready
// handshake. out_last marks the final byte of each word, and word_cnt counts
// fully emitted words, wrapping modulo 2**CNT_W.
//
// Byte order is MSB first by default. Define BYTE_SERIALIZER_LSB_FIRST_EN to
// emit LSB first. The handshake, latency, out_last timing and word_cnt are the
// same in both builds.
//
// A word accepted while the final byte of the previous word is transferring
// is loaded on the same edge. The stream then continues with no bubble.
module byte_serializer #(
  parameter int NUM_BYTES = 4,
  parameter int BYTE_W    = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,     // asynchronous, active low
  byte_serializer_if.slave bus,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int WORD_W = NUM_BYTES * BYTE_W;
  localparam int IDX_W  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,  // no word held
    SEND = 1'b1   // a word is held and its bytes are being emitted
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic               out_valid;
  logic               out_last;
  logic               xfer;
  logic               in_ready;
  logic               accept;
  logic [BYTE_W-1:0]  cur_byte;
  logic [WORD_W-1:0]  shifted;

  // The byte on the output is always at one fixed end of the shift register.
  // After each transfer the register shifts one byte toward that end. The
  // final byte of a word is never shifted out, so in IDLE out_data keeps
  // showing the last emitted byte.
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
  assign cur_byte = shreg_q[BYTE_W-1:0];
  assign shifted  = {{BYTE_W{1'b0}}, shreg_q[WORD_W-1:BYTE_W]};
`else
  assign cur_byte = shreg_q[WORD_W-1 -: BYTE_W];
  assign shifted  = {shreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
`endif

  // Handshake decode. in_ready depends on the registered state and on
  // out_ready. It has no path from in_valid.
  assign out_valid = (state_q == SEND);
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign xfer      = out_valid && bus.out_ready;
  assign in_ready  = (state_q == IDLE) || (xfer && out_last);
  assign accept    = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = cur_byte;
  assign bus.out_last  = out_last;
  assign word_cnt      = cnt_q;

  // Next-state, byte index, shift register and word counter.
  // NOTE: every signal driven here gets a hold value before the case
  // statement. Any path that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SEND;
          idx_d   = '0;
          shreg_d = bus.in_data;
        end
      end

      SEND: begin
        if (xfer) begin
          if (out_last) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (accept) begin
              // Back-to-back: the next word follows with no gap.
              idx_d   = '0;
              shreg_d = bus.in_data;
            end else begin
              // Index and register hold, so out_data keeps the last byte.
              state_d = IDLE;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shifted;
          end
        end
        // While out_ready is low, everything holds and the byte stays stable.
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with asynchronous clear.
  // NOTE: sequential state uses non-blocking assignments only. All
  // registers then update together on the edge, with no dependence on the
  // order of evaluation.
  // NOTE: the datapath register is reset along with the control state,
  // because out_data must read zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Testbench for byte_serializer. It applies table-driven cycle vectors for
// single-word, stalled and back-to-back transfers. Hand-written sequences
// cover a reset asserted mid-word and word_cnt wrap over a 257-word stream.
// Expected byte order follows BYTE_SERIALIZER_LSB_FIRST_EN in the same way
// as the design.
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] word_cnt;

  byte_serializer_if bus ();

  byte_serializer dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] W_A = 32'h86DEF0A3;
  localparam logic [31:0] W_B = 32'h11223344;
  localparam logic [31:0] W_C = 32'hAABBCCDD;
  localparam logic [31:0] W_D = 32'h01020304;

  typedef struct {
    string       tag;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    logic [7:0]  exp_out_data;
    logic        exp_out_last;
    logic [7:0]  exp_word_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // k-th emitted byte of word w (k = 0 is first on the wire).
  function automatic logic [7:0] bsel(input logic [31:0] w, input int k);
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
    return w[8*k +: 8];
`else
    return w[8*(3-k) +: 8];
`endif
  endfunction

  task automatic add(input string tag, input logic v, input logic [31:0] d, input logic r,
                     input logic ir, input logic ov, input logic [7:0] od,
                     input logic ol, input logic [7:0] wc);
    vec_t e;
    e.tag = tag; e.in_valid = v; e.in_data = d; e.out_ready = r;
    e.exp_in_ready = ir; e.exp_out_valid = ov; e.exp_out_data = od;
    e.exp_out_last = ol; e.exp_word_cnt = wc;
    vecs.push_back(e);
  endtask

  // Drive inputs on the falling edge and compare just after. The DUT then
  // acts on them at the next rising edge.
  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      bus.in_valid  = vecs[i].in_valid;
      bus.in_data   = vecs[i].in_data;
      bus.out_ready = vecs[i].out_ready;
      #1;
      check($sformatf("%s[%0d] in_ready",  vecs[i].tag, i), 32'(bus.in_ready),  32'(vecs[i].exp_in_ready));
      check($sformatf("%s[%0d] out_valid", vecs[i].tag, i), 32'(bus.out_valid), 32'(vecs[i].exp_out_valid));
      check($sformatf("%s[%0d] out_data",  vecs[i].tag, i), 32'(bus.out_data),  32'(vecs[i].exp_out_data));
      check($sformatf("%s[%0d] out_last",  vecs[i].tag, i), 32'(bus.out_last),  32'(vecs[i].exp_out_last));
      check($sformatf("%s[%0d] word_cnt",  vecs[i].tag, i), 32'(word_cnt),      32'(vecs[i].exp_word_cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int a_end, b_end, c_end, d_end;
    int bidx [7] = '{0, 1, 1, 1, 2, 3, 3};
    logic rp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Group A: single word, out_ready held high.
    add("t1 accept", 1'b1, W_A, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
    for (int k = 0; k < 4; k++)
      add("t1 byte", 1'b0, 32'h0, 1'b1, (k == 3), 1'b1, bsel(W_A, k), (k == 3), 8'd0);
    add("t1 idle", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, bsel(W_A, 3), 1'b0, 8'd1);
    a_end = vecs.size();

    // Group B: same word with out_ready pattern 1,0,0,1,1,0,1.
    add("t2 accept", 1'b1, W_A, 1'b1, 1'b1, 1'b0, bsel(W_A, 3), 1'b0, 8'd1);
    for (int i = 0; i < 7; i++)
      add("t2 byte", 1'b0, 32'h0, rp[i], (bidx[i] == 3) && rp[i], 1'b1,
          bsel(W_A, bidx[i]), (bidx[i] == 3), 8'd1);
    add("t2 idle", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, bsel(W_A, 3), 1'b0, 8'd2);
    b_end = vecs.size();

    // Group C: back-to-back words. W_C is offered while busy and must be
    // taken only on W_B's final byte.
    add("t3 accept", 1'b1, W_B, 1'b1, 1'b1, 1'b0, bsel(W_A, 3), 1'b0, 8'd2);
    for (int k = 0; k < 4; k++)
      add("t3 w1", 1'b1, W_C, 1'b1, (k == 3), 1'b1, bsel(W_B, k), (k == 3), 8'd2);
    for (int k = 0; k < 4; k++)
      add("t3 w2", 1'b0, 32'h0, 1'b1, (k == 3), 1'b1, bsel(W_C, k), (k == 3), 8'd3);
    add("t3 idle", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, bsel(W_C, 3), 1'b0, 8'd4);
    c_end = vecs.size();

    // Group D: first word after a mid-word reset.
    add("t4 accept", 1'b1, W_D, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0);
    for (int k = 0; k < 4; k++)
      add("t4 byte", 1'b0, 32'h0, 1'b1, (k == 3), 1'b1, bsel(W_D, k), (k == 3), 8'd0);
    add("t4 idle", 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, bsel(W_D, 3), 1'b0, 8'd1);
    d_end = vecs.size();

    // Reset state.
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("reset in_ready",  32'(bus.in_ready),  32'h1);
    check("reset out_valid", 32'(bus.out_valid), 32'h0);
    check("reset out_data",  32'(bus.out_data),  32'h0);
    check("reset out_last",  32'(bus.out_last),  32'h0);
    check("reset word_cnt",  32'(word_cnt),      32'h0);
    @(negedge clk);
    reset = 1'b1;

    run_vectors(0, a_end);
    run_vectors(a_end, b_end);
    run_vectors(b_end, c_end);

    // Mid-word reset: accept W_A, transfer two bytes, then pull reset low
    // between clock edges while the third byte is on the output.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = W_A; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.in_data = 32'h0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("t4 pre-reset out_valid", 32'(bus.out_valid), 32'h1);
    check("t4 pre-reset out_data",  32'(bus.out_data),  32'(bsel(W_A, 2)));
    check("t4 pre-reset word_cnt",  32'(word_cnt),      32'h4);
    #1;
    reset = 1'b0;
    #1;
    check("t4 async out_valid", 32'(bus.out_valid), 32'h0);
    check("t4 async out_last",  32'(bus.out_last),  32'h0);
    check("t4 async out_data",  32'(bus.out_data),  32'h0);
    check("t4 async word_cnt",  32'(word_cnt),      32'h0);
    check("t4 async in_ready",  32'(bus.in_ready),  32'h1);
    @(negedge clk);
    reset = 1'b1;

    run_vectors(c_end, d_end);

    // word_cnt wrap: stream 257 back-to-back words from a fresh reset.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    begin
      int         acc  = 0;
      int         done = 0;
      bit         fin  = 1'b0;
      bit         tick_done;
      logic [8:0] q[$];
      logic [8:0] head;
      logic [31:0] w;
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
        @(negedge clk);
        w = {4{acc[7:0]}} ^ 32'h00FF5AA5;
        bus.in_valid  = (acc < 257);
        bus.in_data   = w;
        bus.out_ready = 1'b1;
        #1;
        tick_done = 1'b0;
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            check("stream byte without word", 32'(bus.out_valid), 32'h0);
          end else begin
            head = q.pop_front();
            check($sformatf("stream w%0d out_data", done), 32'(bus.out_data), 32'(head[7:0]));
            check($sformatf("stream w%0d out_last", done), 32'(bus.out_last), 32'(head[8]));
            if (head[8]) begin
              done++;
              tick_done = 1'b1;
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          for (int k = 0; k < 4; k++)
            q.push_back({(k == 3), bsel(w, k)});
          acc++;
        end
        @(posedge clk);
        #1;
        if (tick_done && done == 256)
          check("t5 word_cnt after 256", 32'(word_cnt), 32'h00);
        if (tick_done && done == 257) begin
          check("t5 word_cnt after 257", 32'(word_cnt), 32'h01);
          fin = 1'b1;
        end
      end
      if (!fin)
        check("t5 stream timeout words done", 32'(done), 32'd257);
    end

    bus.in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
